// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline controller: redirect selects and FSM states.
package pipe_pkg;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard: a used decode source matches the destination of a load
// that is still too early in the pipe to forward (stages 2..LD_STAGE).
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int REGW     = 5,
  parameter int LD_STAGE = 3
) (
  input  logic              i_de_v,
  input  logic [REGW-1:0]   i_rs1,
  input  logic              i_rs1_use,
  input  logic [REGW-1:0]   i_rs2,
  input  logic              i_rs2_use,
  input  logic [NSTAGE-1:0] i_stage_v,
  input  logic [NSTAGE-1:0] i_stage_we,
  input  logic [NSTAGE-1:0] i_stage_ld,
  input  logic [REGW-1:0]   i_stage_rd [NSTAGE],
  output logic              o_haz
);

  logic w_hit1;
  logic w_hit2;
  logic w_unused;

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int k = 2; k <= LD_STAGE; k++) begin
      // x0 is hardwired, so a load targeting it never blocks a reader
      if (i_stage_v[k] && i_stage_we[k] && i_stage_ld[k] && (i_stage_rd[k] != '0)) begin
        if (i_stage_rd[k] == i_rs1) w_hit1 = 1'b1;
        if (i_stage_rd[k] == i_rs2) w_hit2 = 1'b1;
      end
    end
  end

  always_comb begin
    w_unused = ^{i_stage_v, i_stage_we, i_stage_ld};
    for (int k = 0; k < NSTAGE; k++) w_unused = w_unused ^ (^i_stage_rd[k]);
  end

  assign o_haz = i_de_v & ((i_rs1_use & w_hit1) | (i_rs2_use & w_hit2));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage valid/enable/kill, load-use stall,
// memory freeze, branch redirect, exception trap and interrupt drain FSM.
//   state | meaning
//   RUN   | normal issue
//   DRAIN | decode held, waiting for stages 2..NSTAGE-1 to empty
//   TRAP  | one-cycle trap entry, then back to RUN
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NSTAGE   = 5,
  parameter int REGW     = 5,
  parameter int BR_STAGE = 2,
  parameter int LD_STAGE = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              DE_V,
  input  logic [REGW-1:0]   DE_RS1,
  input  logic [REGW-1:0]   DE_RS2,
  input  logic              DE_RS1_USE,
  input  logic              DE_RS2_USE,
  input  logic [REGW-1:0]   DE_RD,
  input  logic              DE_RD_WE,
  input  logic              DE_IS_LOAD,
  input  logic              MEM_BUSY,
  input  logic              BR_TAKEN,
  input  logic              EXC,
  input  logic              INT_REQ,
  output logic [NSTAGE-1:0] STAGE_V,
  output logic [NSTAGE-1:0] STAGE_EN,
  output logic [NSTAGE-1:0] FLUSH,
  output logic [1:0]        PC_SEL,
  output logic              HAZ_STALL,
  output logic [1:0]        CTRL_STATE
);

  localparam bit BR_FREEZABLE = (BR_STAGE <= LD_STAGE);

  ctrl_state_t       r_state;
  logic [NSTAGE-1:0] r_v;
  logic [NSTAGE-1:0] r_we;
  logic [NSTAGE-1:0] r_ld;
  logic [REGW-1:0]   r_rd [NSTAGE];

  logic              w_haz;
  logic              w_exc;
  logic              w_br;
  logic              w_drained;
  logic              w_dtrap;
  logic              w_hold;
  logic [NSTAGE-1:0] w_en;
  logic [NSTAGE-1:0] w_flush;
  logic [NSTAGE-1:0] w_bubble;
  logic [NSTAGE-1:0] w_vin;
  logic [NSTAGE-1:0] w_wein;
  logic [NSTAGE-1:0] w_ldin;
  logic [REGW-1:0]   w_rdin [NSTAGE];

  hazard_detect #(
    .NSTAGE   (NSTAGE),
    .REGW     (REGW),
    .LD_STAGE (LD_STAGE)
  ) u_haz (
    .i_de_v     (DE_V),
    .i_rs1      (DE_RS1),
    .i_rs1_use  (DE_RS1_USE),
    .i_rs2      (DE_RS2),
    .i_rs2_use  (DE_RS2_USE),
    .i_stage_v  (r_v),
    .i_stage_we (r_we),
    .i_stage_ld (r_ld),
    .i_stage_rd (r_rd),
    .o_haz      (w_haz)
  );

  assign w_exc     = EXC & r_v[NSTAGE-1];
  assign w_br      = BR_TAKEN & r_v[BR_STAGE] & ~w_exc & ~(MEM_BUSY & BR_FREEZABLE);
  assign w_drained = ~|r_v[NSTAGE-1:2];
  assign w_dtrap   = (r_state == ST_DRAIN) & INT_REQ & w_drained & ~w_exc;
  assign w_hold    = w_haz | (r_state == ST_DRAIN);

  always_comb begin
    w_en    = '1;
    w_flush = '0;
    PC_SEL  = PC_SEQ;
    if (w_exc) begin
      w_flush = '1;
      PC_SEL  = PC_TRAP;
    end else begin
      if (MEM_BUSY) begin
        for (int k = 0; k <= LD_STAGE; k++) w_en[k] = 1'b0;
      end else if (w_hold) begin
        w_en[1:0] = 2'b00;
      end
      if (w_br) begin
        for (int k = 0; k < BR_STAGE; k++) w_flush[k] = 1'b1;
        PC_SEL = PC_BRANCH;
      end else if (w_dtrap) begin
        w_flush[1:0] = 2'b11;
        PC_SEL       = PC_TRAP;
      end
    end
    if (RESET) PC_SEL = PC_SEQ;
  end

  // A stage that advances while its upstream neighbour is held takes a bubble;
  // an instruction killed upstream must not slip into the next stage either.
  always_comb begin
    w_bubble = '0;
    w_vin    = '0;
    w_wein   = '0;
    w_ldin   = '0;
    for (int k = 0; k < NSTAGE; k++) w_rdin[k] = '0;
    w_vin[0] = 1'b1;
    w_vin[1] = r_v[0] & ~w_flush[0];
    w_vin[2] = r_v[1] & DE_V & ~w_flush[1];
    w_wein[2] = DE_RD_WE & w_vin[2];
    w_ldin[2] = DE_IS_LOAD & w_vin[2];
    w_rdin[2] = DE_RD;
    for (int k = 1; k < NSTAGE; k++) w_bubble[k] = w_en[k] & ~w_en[k-1];
    for (int k = 3; k < NSTAGE; k++) begin
      w_vin[k]  = r_v[k-1] & ~w_flush[k-1];
      w_wein[k] = r_we[k-1] & w_vin[k];
      w_ldin[k] = r_ld[k-1] & w_vin[k];
      w_rdin[k] = r_rd[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_v  <= '0;
      r_we <= '0;
      r_ld <= '0;
      for (int k = 0; k < NSTAGE; k++) r_rd[k] <= '0;
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (w_flush[k] || w_bubble[k]) begin
          r_v[k]  <= 1'b0;
          r_we[k] <= 1'b0;
          r_ld[k] <= 1'b0;
        end else if (w_en[k]) begin
          r_v[k]  <= w_vin[k];
          r_we[k] <= w_wein[k];
          r_ld[k] <= w_ldin[k];
          r_rd[k] <= w_rdin[k];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_exc)        r_state <= ST_TRAP;
          else if (INT_REQ) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_exc)          r_state <= ST_TRAP;
          else if (!INT_REQ)  r_state <= ST_RUN;
          else if (w_drained) r_state <= ST_TRAP;
        end
        ST_TRAP: begin
          if (w_exc) r_state <= ST_TRAP;
          else       r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign STAGE_V    = r_v;
  assign STAGE_EN   = w_en;
  assign FLUSH      = w_flush;
  assign HAZ_STALL  = w_haz;
  assign CTRL_STATE = r_state;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGE, default 5, number of pipeline stages; stage 0 is fetch, stage 1 is decode, stage NSTAGE-1 is writeback.
REQ-002 Parameter REGW, default 5, register-id width.
REQ-003 Parameter BR_STAGE, default 2, stage that resolves taken branches/jumps.
REQ-004 Parameter LD_STAGE, default 3, last stage whose load result is not yet forwardable.
REQ-005 Ports: CLK  in  1  clock; RESET  in  1  reset.
REQ-006 Ports: DE_V  in  1  valid instruction in decode.
REQ-007 Ports: DE_RS1, DE_RS2  in  REGW  source ids; DE_RS1_USE, DE_RS2_USE  in  1  source used.
REQ-008 Ports: DE_RD  in  REGW  destination id; DE_RD_WE  in  1  writes rd; DE_IS_LOAD  in  1  load.
REQ-009 Ports: MEM_BUSY  in  1  memory stage waiting; BR_TAKEN  in  1  redirect from BR_STAGE.
REQ-010 Ports: EXC  in  1  exception at stage NSTAGE-1; INT_REQ  in  1  level interrupt request.
REQ-011 Ports: STAGE_V  out  NSTAGE  per-stage valid; STAGE_EN  out  NSTAGE  per-stage advance enable; FLUSH  out  NSTAGE  per-stage kill.
REQ-012 Ports: PC_SEL  out  2  00 sequential, 01 branch, 10 trap; HAZ_STALL  out  1  load-use stall; CTRL_STATE  out  2  FSM state.
REQ-013 One clock; reset is synchronous and active-high. Clock port is CLK, reset port is RESET.

Function
REQ-014 The block SHALL hold registered valid, rd, rd_we and is_load for stages 1..NSTAGE-1; these fields advance with STAGE_EN.
REQ-015 HAZ_STALL SHALL be 1 when DE_V and a used source equals the rd of a valid load with rd_we in stages 2..LD_STAGE; rd equal to 0 SHALL never raise a hazard.
REQ-016 On HAZ_STALL, STAGE_EN[0..1] SHALL be 0 and a bubble (valid 0) SHALL enter stage 2.
REQ-017 On MEM_BUSY, STAGE_EN[0..LD_STAGE] SHALL be 0 and a bubble SHALL enter stage LD_STAGE+1.
REQ-018 A taken branch (BR_TAKEN and STAGE_V[BR_STAGE], stage not frozen) SHALL drive PC_SEL=01 and FLUSH[0..BR_STAGE-1]=1 in the same cycle; those stages SHALL read invalid next cycle.
REQ-019 EXC with STAGE_V[NSTAGE-1] SHALL drive PC_SEL=10 and FLUSH all stages, and SHALL set the state to TRAP for one cycle.
REQ-020 FSM states: RUN=0, DRAIN=1, TRAP=2.
REQ-021 RUN to DRAIN: on INT_REQ. In DRAIN, decode SHALL be held (STAGE_EN[0..1]=0) and bubbles SHALL enter stage 2.
REQ-022 DRAIN to TRAP: when STAGE_V[2..NSTAGE-1] are all 0. In that cycle the block SHALL drive PC_SEL=10 and FLUSH[0..1].
REQ-023 DRAIN to RUN: if INT_REQ drops before drain completes; no trap SHALL be taken.
REQ-024 TRAP to RUN: unconditionally after one cycle.
REQ-025 Priority SHALL be RESET > EXC > BR_TAKEN > MEM_BUSY > HAZ_STALL/DRAIN hold.
REQ-026 EXC in DRAIN SHALL win and go to TRAP. A branch in DRAIN SHALL be honoured and the state SHALL stay DRAIN.
REQ-027 STAGE_EN, FLUSH, PC_SEL and HAZ_STALL SHALL be combinational from current state and inputs. STAGE_V and CTRL_STATE SHALL be registered.
REQ-028 A stage with FLUSH=1 SHALL load valid 0 regardless of STAGE_EN.
REQ-029 STAGE_V[0] SHALL become 1 on the first cycle after RESET deasserts and SHALL stay 1 unless flushed or held.

Reset
REQ-030 While RESET is high, all STAGE_V bits and all stage rd_we/is_load bits SHALL be 0, CTRL_STATE=RUN and PC_SEL=00.
REQ-031 Reset mid-operation SHALL discard all in-flight state, including DRAIN, within the same edge.

Structure
REQ-032 The package pipe_pkg SHALL hold the PC_SEL encodings and the FSM state encodings.
REQ-033 The load-use comparison SHALL be one parametrised sub-module, hazard_detect (combinational, NSTAGE/REGW/LD_STAGE).

Verification
REQ-034 Load x5 in stage 2, decode uses rs1=5 -> HAZ_STALL=1 for 1 cycle (2 cycles if LD_STAGE=3 and the load is still in stage 3), bubble in stage 2.
REQ-035 Load to x0, decode uses rs1=0 -> HAZ_STALL=0.
REQ-036 BR_TAKEN with stage 2 valid -> PC_SEL=01 same cycle; STAGE_V[0..1]=0 next cycle; STAGE_V[2] intact.
REQ-037 MEM_BUSY held 3 cycles -> stages 0..3 frozen, 3 bubbles into stage 4, contents unchanged on release.
REQ-038 INT_REQ with stages 2..4 valid -> DRAIN 3 cycles, then PC_SEL=10 and TRAP for 1 cycle, then RUN; same stimulus with EXC on the 2nd drain cycle -> immediate TRAP with all stages flushed.
REQ-039 RESET asserted during DRAIN -> next cycle STAGE_V=0 and CTRL_STATE=RUN.
